// File: rtl/salsa_sched.sv
// Round-robin slot scheduler for an interleaved salsa/scrypt ROMix core: one slot per pipeline stage.
// Optional completed-hash counter is built only when SALSA_SCHED_HASHCNT_EN is defined.
module salsa_sched #(
    parameter int SLOTS = 8,
    parameter int ITER  = 1024,
    parameter int AW    = 10,
    parameter int SW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [AW-1:0]       xaddr,
    output logic [SW-1:0]       issue_slot,
    output logic [1:0]          feed_sel,
    output logic                ram_we,
    output logic [SW+AW-1:0]    ram_waddr,
    output logic [SW+AW-1:0]    ram_raddr,
    output logic                done_valid,
    output logic [SW-1:0]       done_slot,
    output logic                busy,
    output logic [31:0]         hash_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    localparam logic [1:0] FEED_BUBBLE = 2'd0;
    localparam logic [1:0] FEED_LOAD   = 2'd1;
    localparam logic [1:0] FEED_WRITE  = 2'd2;
    localparam logic [1:0] FEED_READ   = 2'd3;

    localparam logic [AW:0]   CNT_LAST_WR = (AW+1)'(ITER - 1);
    localparam logic [AW:0]   CNT_DONE    = (AW+1)'(ITER);
    localparam logic [SW-1:0] PTR_LAST    = SW'(SLOTS - 1);

    logic [SW-1:0] ptr_r;
    logic [1:0]    state_r [SLOTS];
    logic [AW:0]   cnt_r   [SLOTS];
    logic          busy_r;

    logic [1:0]    cur_state_s;
    logic [AW:0]   cur_cnt_s;
    logic [1:0]    next_state_s;
    logic [AW:0]   next_cnt_s;
    logic          load_ready_s;
    logic [1:0]    feed_sel_s;
    logic          ram_we_s;
    logic [AW-1:0] widx_s;
    logic          done_s;
    logic          busy_next_s;

    assign cur_state_s = state_r[ptr_r];
    assign cur_cnt_s   = cnt_r[ptr_r];

    // Decode the visit of the pointed slot; reset forces every strobe quiet.
    always_comb begin
        load_ready_s = 1'b0;
        feed_sel_s   = FEED_BUBBLE;
        ram_we_s     = 1'b0;
        widx_s       = '0;
        done_s       = 1'b0;
        next_state_s = cur_state_s;
        next_cnt_s   = cur_cnt_s;
        if (reset) begin
            next_state_s = ST_IDLE;
            next_cnt_s   = '0;
        end else begin
            case (cur_state_s)
                ST_IDLE: begin
                    load_ready_s = 1'b1;
                    if (load_valid) begin
                        feed_sel_s   = FEED_LOAD;
                        ram_we_s     = 1'b1;
                        next_cnt_s   = (AW+1)'(1);
                        next_state_s = ST_WRITE;
                    end else begin
                        feed_sel_s   = FEED_BUBBLE;
                    end
                end
                ST_WRITE: begin
                    feed_sel_s = FEED_WRITE;
                    ram_we_s   = 1'b1;
                    widx_s     = cur_cnt_s[AW-1:0];
                    if (cur_cnt_s == CNT_LAST_WR) begin
                        next_cnt_s   = '0;
                        next_state_s = ST_READ;
                    end else begin
                        next_cnt_s   = cur_cnt_s + (AW+1)'(1);
                    end
                end
                ST_READ: begin
                    if (cur_cnt_s < CNT_DONE) begin
                        feed_sel_s = FEED_READ;
                        next_cnt_s = cur_cnt_s + (AW+1)'(1);
                    end else begin
                        // Completion visit doubles as a load slot so the pipeline never idles.
                        done_s       = 1'b1;
                        load_ready_s = 1'b1;
                        if (load_valid) begin
                            feed_sel_s   = FEED_LOAD;
                            ram_we_s     = 1'b1;
                            next_cnt_s   = (AW+1)'(1);
                            next_state_s = ST_WRITE;
                        end else begin
                            next_cnt_s   = '0;
                            next_state_s = ST_IDLE;
                        end
                    end
                end
                default: begin
                    next_cnt_s   = '0;
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Activity as it will be after this edge: pointed slot takes its next state.
    always_comb begin
        busy_next_s = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (ptr_r == SW'(i)) begin
                if (next_state_s != ST_IDLE) busy_next_s = 1'b1;
                else                         busy_next_s = busy_next_s;
            end else begin
                if (state_r[i] != ST_IDLE)   busy_next_s = 1'b1;
                else                         busy_next_s = busy_next_s;
            end
        end
    end

    // Pointer rotation and per-slot state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r  <= '0;
            busy_r <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= '0;
            end
        end else begin
            if (ptr_r == PTR_LAST) ptr_r <= '0;
            else                   ptr_r <= ptr_r + SW'(1);
            state_r[ptr_r] <= next_state_s;
            cnt_r[ptr_r]   <= next_cnt_s;
            busy_r         <= busy_next_s;
        end
    end

`ifdef SALSA_SCHED_HASHCNT_EN
    logic [31:0] hash_count_r;

    // Completed-hash counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)       hash_count_r <= 32'd0;
        else if (done_s) hash_count_r <= hash_count_r + 32'd1;
        else             hash_count_r <= hash_count_r;
    end

    assign hash_count = hash_count_r;
`else
    assign hash_count = 32'd0;
`endif

    assign issue_slot = ptr_r;
    assign load_ready = load_ready_s;
    assign feed_sel   = feed_sel_s;
    assign ram_we     = ram_we_s;
    assign ram_waddr  = {ptr_r, widx_s};
    assign ram_raddr  = {ptr_r, xaddr};
    assign done_valid = done_s;
    assign done_slot  = ptr_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_salsa_sched.sv
// Self-checking bench for salsa_sched (SLOTS=8, ITER=4): vector table, directed sequences and a
// randomized run against a job-timeline reference model.
module tb_salsa_sched;
    localparam int SLOTS = 8;
    localparam int ITER  = 4;
    localparam int AW    = 2;
    localparam int SW    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_valid = 1'b0;
    logic [AW-1:0] xaddr = '0;
    logic load_ready, ram_we, done_valid, busy;
    logic [SW-1:0] issue_slot, done_slot;
    logic [1:0] feed_sel;
    logic [SW+AW-1:0] ram_waddr, ram_raddr;
    logic [31:0] hash_count;

    always #5 clk = ~clk;

    salsa_sched #(.SLOTS(SLOTS), .ITER(ITER), .AW(AW), .SW(SW)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .xaddr(xaddr), .issue_slot(issue_slot), .feed_sel(feed_sel), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .done_valid(done_valid),
        .done_slot(done_slot), .busy(busy), .hash_count(hash_count)
    );

    typedef struct {
        int cyc; int feed; int we; int wa; int done; int lr;
    } vec_t;

    int tests = 0;
    int fails = 0;
    // Model: cycle each slot's current job was loaded (-1 = idle), cycles since reset release.
    int start [SLOTS];
    int cyc = 0;
    bit busy_exp = 1'b0;
    bit busy_known = 1'b0;
    int hc_exp = 0;

    function automatic int exp_hc();
`ifdef SALSA_SCHED_HASHCNT_EN
        return hc_exp;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs after the edge, compare mid-cycle against the model, advance the model.
    task automatic tick(input bit rst, input bit lv, input int xa);
        int p, k, e_lr, e_feed, e_we, e_wa, e_done;
        bit acc;
        @(posedge clk); #1;
        reset = rst; load_valid = lv; xaddr = AW'(xa);
        @(negedge clk);
        p = cyc % SLOTS;
        e_lr = 0; e_feed = 0; e_we = 0; e_wa = 0; e_done = 0; acc = 1'b0;
        if (!rst) begin
            k = (start[p] < 0) ? -1 : (cyc - start[p]) / SLOTS;
            if (k < 0 || k == 2*ITER) begin
                e_lr = 1; e_done = (k == 2*ITER) ? 1 : 0; acc = lv;
                if (lv) begin e_feed = 1; e_we = 1; e_wa = p*ITER; end
            end else if (k < ITER) begin
                e_feed = 2; e_we = 1; e_wa = p*ITER + k;
            end else begin
                e_feed = 3;
            end
            chk("issue_slot", issue_slot, p);
            chk("ram_raddr", ram_raddr, p*ITER + xa);
        end
        chk("load_ready", load_ready, e_lr);
        chk("feed_sel", feed_sel, e_feed);
        chk("ram_we", ram_we, e_we);
        chk("done_valid", done_valid, e_done);
        if (e_we != 0)   chk("ram_waddr", ram_waddr, e_wa);
        if (e_done != 0) chk("done_slot", done_slot, p);
        if (busy_known) begin
            chk("busy", busy, busy_exp);
            chk("hash_count", hash_count, exp_hc());
        end
        if (rst) begin
            foreach (start[i]) start[i] = -1;
            cyc = 0; hc_exp = 0; busy_exp = 1'b0; busy_known = 1'b1;
        end else begin
            if (e_done != 0) begin hc_exp++; start[p] = -1; end
            if (acc) start[p] = cyc;
            cyc++;
            busy_exp = 1'b0;
            foreach (start[i]) if (start[i] >= 0) busy_exp = 1'b1;
        end
    endtask

    initial begin
        vec_t vt [9];
        int w0_cnt, r3_cnt, done_cnt;
        foreach (start[i]) start[i] = -1;
        // Single job loaded into slot 0 at cycle 0.
        vt[0] = '{cyc: 0,  feed: 1, we: 1, wa: 8'h00, done: 0, lr: 1};
        vt[1] = '{cyc: 1,  feed: 0, we: 0, wa: 0,     done: 0, lr: 1};
        vt[2] = '{cyc: 8,  feed: 2, we: 1, wa: 8'h01, done: 0, lr: 0};
        vt[3] = '{cyc: 16, feed: 2, we: 1, wa: 8'h02, done: 0, lr: 0};
        vt[4] = '{cyc: 24, feed: 2, we: 1, wa: 8'h03, done: 0, lr: 0};
        vt[5] = '{cyc: 32, feed: 3, we: 0, wa: 0,     done: 0, lr: 0};
        vt[6] = '{cyc: 56, feed: 3, we: 0, wa: 0,     done: 0, lr: 0};
        vt[7] = '{cyc: 64, feed: 0, we: 0, wa: 0,     done: 1, lr: 1};
        vt[8] = '{cyc: 65, feed: 0, we: 0, wa: 0,     done: 0, lr: 1};

        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_hash_count", hash_count, 0);
        chk("reset_load_ready", load_ready, 0);

        w0_cnt = 0; r3_cnt = 0;
        for (int c = 0; c < 70; c++) begin
            tick(1'b0, c == 0, c % ITER);
            if (ram_we && issue_slot == 3'd0) w0_cnt++;
            if (feed_sel == 2'd3) r3_cnt++;
            foreach (vt[i]) begin
                if (vt[i].cyc == c) begin
                    chk("vec_feed", feed_sel, vt[i].feed);
                    chk("vec_we", ram_we, vt[i].we);
                    if (vt[i].we != 0) chk("vec_waddr", ram_waddr, vt[i].wa);
                    chk("vec_done", done_valid, vt[i].done);
                    chk("vec_load_ready", load_ready, vt[i].lr);
                end
            end
        end
        chk("slot0_writes", w0_cnt, ITER);
        chk("read_visits", r3_cnt, ITER);

        // Reset partway through a job: it must vanish without completing.
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 0);
        for (int c = 1; c < 30; c++) tick(1'b0, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_slot0", issue_slot, 0);
        done_cnt = 0;
        for (int c = 1; c < 80; c++) begin
            tick(1'b0, 1'b0, 0);
            if (done_valid) done_cnt++;
        end
        chk("midreset_no_done", done_cnt, 0);
        tick(1'b0, 1'b1, 0);
        chk("reload_slot", issue_slot, 0);
        chk("reload_feed", feed_sel, 1);

        // Saturated load: every slot loads, completes and reloads back-to-back.
        tick(1'b1, 1'b0, 0);
        for (int c = 0; c < 140; c++) begin
            tick(1'b0, 1'b1, $urandom_range(0, ITER-1));
            if (c >= 64 && c < 72) begin
                chk("sat_done", done_valid, 1);
                chk("sat_done_slot", done_slot, c - 64);
                chk("sat_reload", load_ready, 1);
            end
            if (c >= 1) chk("sat_busy", busy, 1);
`ifdef SALSA_SCHED_HASHCNT_EN
            if (c == 136) chk("hash_count_136", hash_count, 16);
`else
            if (c == 136) chk("hash_count_136", hash_count, 0);
`endif
        end

        // Random offers, addresses and occasional resets against the model.
        for (int c = 0; c < 1500; c++) begin
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, ITER-1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/salsa_sched.md
SALSA_SCHED -- requirements
Module: salsa_sched

Interface
REQ-001 SHALL have parameter SLOTS, default 8, meaning concurrent jobs; it equals the salsa pipeline latency in clocks.
REQ-002 SHALL have parameter ITER, default 1024, meaning scratchpad entries per job; it is a power of two.
REQ-003 SHALL have parameter AW, default 10, meaning log2(ITER).
REQ-004 SHALL have parameter SW, default 3, meaning log2(SLOTS).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load_valid  input  1  a new job (B, Bx) is offered by the datapath.
REQ-008 load_ready  output  1  the current slot accepts the offered job this cycle.
REQ-009 xaddr  input  AW  salsa Xaddr for the result emerging this cycle.
REQ-010 issue_slot  output  SW  slot whose data enters the salsa pipeline this cycle.
REQ-011 feed_sel  output  2  0=bubble, 1=load new B/Bx, 2=feedback (write phase), 3=feedback XOR scratchpad (read phase).
REQ-012 ram_we  output  1  scratchpad write strobe.
REQ-013 ram_waddr  output  SW+AW  scratchpad write address {slot, index}.
REQ-014 ram_raddr  output  SW+AW  scratchpad read address {slot, xaddr}.
REQ-015 done_valid  output  1  the emerging result of done_slot is a final hash.
REQ-016 done_slot  output  SW  slot that completed.
REQ-017 busy  output  1  at least one slot is not IDLE.
REQ-018 hash_count  output  32  completed-job counter (see Configuration).

Function
REQ-019 A slot pointer SHALL advance 0..SLOTS-1 by one each clock and wrap to 0; issue_slot SHALL equal the pointer.
REQ-020 Each slot SHALL hold a state (IDLE, WRITE, READ) and an AW+1-bit visit counter cnt; only the pointed slot's state changes in a cycle.
REQ-021 IDLE visit: load_ready=1; if load_valid, feed_sel=1, ram_we=1, ram_waddr={slot,0}, cnt<=1, state<=WRITE; otherwise feed_sel=0 and ram_we=0.
REQ-022 WRITE visit: feed_sel=2, ram_we=1, ram_waddr={slot,cnt[AW-1:0]}; cnt<=cnt+1; when cnt==ITER-1, cnt<=0 and state<=READ.
REQ-023 READ visit with cnt<ITER: feed_sel=3, ram_we=0, ram_raddr={slot,xaddr}; cnt<=cnt+1.
REQ-024 READ visit with cnt==ITER: done_valid=1, done_slot=slot, state<=IDLE, and load_ready=1 in the same cycle.
REQ-025 In the REQ-024 cycle, if load_valid=1 the new job SHALL be accepted as in REQ-021, with no bubble between completion and reload.
REQ-026 load_ready SHALL be 0 on WRITE and READ visits, except the REQ-024 completion visit.
REQ-027 ram_raddr SHALL be combinational from the pointer and xaddr; all other outputs SHALL be combinational from registered state, except busy and hash_count, which are registered.
REQ-028 Per job, done_valid SHALL occur exactly 2*ITER*SLOTS clocks after the load cycle.
REQ-029 ram_we and feed_sel=3 SHALL never be active together.

Reset
REQ-030 While reset=1: all slots IDLE, pointer=0, all cnt=0, busy=0, hash_count=0.
REQ-031 In any cycle with reset=1: load_ready=0, ram_we=0, done_valid=0, feed_sel=0.
REQ-032 Reset asserted mid-job SHALL discard all jobs without producing done_valid.
REQ-033 The first cycle after reset deasserts SHALL be a visit of slot 0.

Configuration
REQ-034 With macro SALSA_SCHED_HASHCNT_EN defined, hash_count SHALL increment by 1, wrapping at 2^32, on the clock edge ending each done_valid cycle.
REQ-035 Without SALSA_SCHED_HASHCNT_EN, hash_count SHALL be constant 0 and no counter register SHALL be built.

Verification (bench uses ITER=4, AW=2, SLOTS=8)
REQ-036 Reset, then load_valid=1 for one cycle at slot 0 (cycle t) -> ram_we visits at slot 0 with index 0,1,2,3; feed_sel=3 on 4 visits; done_valid with done_slot=0 at t+64.
REQ-037 load_valid held high from reset release -> all 8 slots load in cycles 0..7; done_slot sequence 0..7 at cycles 64..71; each done cycle also reloads (load_ready=1); busy stays 1.
REQ-038 Drive xaddr=2 during slot 5 READ visits -> ram_raddr=0x16 ({5,2}) on those cycles and ram_we=0.
REQ-039 Assert reset at cycle 30 of the REQ-036 job -> no done_valid afterwards; busy=0 one cycle later; the next load is accepted at slot 0.
REQ-040 With SALSA_SCHED_HASHCNT_EN, run REQ-037 for 2 rounds -> hash_count=16 at cycle 136; without the macro -> hash_count=0 throughout.
